segment_sequencer: RTL and testbench

- Double-buffered parameter bank and segment timer for the NUM_CH-channel waveform engine.
- Host-side writes fill a shadow bank of amplitude/offset/phaseword triples. A commit queues the bank together with its duration.
- The sequencer copies the shadow bank into the active bank and pulses the engine reset. It counts the segment down, then either swaps in the queued segment seamlessly or stops and pulses finished.
- Sits between the pipe-in endpoints (after any clock-domain crossing) and the summing engine; single clock domain.

---
 rtl/seg_seq_pkg.sv | 24 ++
 rtl/seg_bank.sv | 70 +++++++
 rtl/segment_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_segment_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_seq_pkg
//  Description : Shared definitions for the segment sequencer: shadow-write
//                field codes, sequencer state encoding and default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_seq_pkg;

    localparam int c_DEFAULT_DATA_W = 16;
    localparam int c_DEFAULT_TIME_W = 16;

    // Field selector codes on the shadow write interface (code 3 is ignored)
    localparam logic [1:0] FIELD_AMP       = 2'd0;
    localparam logic [1:0] FIELD_OFFSET    = 2'd1;
    localparam logic [1:0] FIELD_PHASEWORD = 2'd2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seg_state_t;

endpackage
`default_nettype wire

// File: rtl/seg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : seg_bank
//  Description : NUM_CH x {amp, offset, phaseword} register bank with one
//                indexed write port and a bulk-copy load port. Contents are
//                presented as flat buses, channel k at [k*DATA_W +: DATA_W].
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                i_wr_en/field/idx/data - single-entry write
//                i_load, i_load_*    - copy whole bank (wins over write)
//                o_amps/offsets/phasewords - flat read buses
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_bank
    import seg_seq_pkg::*;
#(
    parameter int NUM_CH = 64,
    parameter int DATA_W = c_DEFAULT_DATA_W,
    parameter int PTR_W  = $clog2(NUM_CH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [1:0]               i_wr_field,
    input  logic [PTR_W-1:0]         i_wr_idx,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_load,
    input  logic [NUM_CH*DATA_W-1:0] i_load_amps,
    input  logic [NUM_CH*DATA_W-1:0] i_load_offsets,
    input  logic [NUM_CH*DATA_W-1:0] i_load_phasewords,
    output logic [NUM_CH*DATA_W-1:0] o_amps,
    output logic [NUM_CH*DATA_W-1:0] o_offsets,
    output logic [NUM_CH*DATA_W-1:0] o_phasewords
);

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            logic [DATA_W-1:0] r_amp;
            logic [DATA_W-1:0] r_offset;
            logic [DATA_W-1:0] r_phaseword;
            logic              w_sel;

            assign w_sel = i_wr_en && (i_wr_idx == PTR_W'(k));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_amp       <= '0;
                    r_offset    <= '0;
                    r_phaseword <= '0;
                end else if (i_load) begin
                    r_amp       <= i_load_amps[k*DATA_W +: DATA_W];
                    r_offset    <= i_load_offsets[k*DATA_W +: DATA_W];
                    r_phaseword <= i_load_phasewords[k*DATA_W +: DATA_W];
                end else if (w_sel) begin
                    case (i_wr_field)
                        FIELD_AMP:       r_amp       <= i_wr_data;
                        FIELD_OFFSET:    r_offset    <= i_wr_data;
                        FIELD_PHASEWORD: r_phaseword <= i_wr_data;
                        default:         ;
                    endcase
                end
            end

            assign o_amps[k*DATA_W +: DATA_W]       = r_amp;
            assign o_offsets[k*DATA_W +: DATA_W]    = r_offset;
            assign o_phasewords[k*DATA_W +: DATA_W] = r_phaseword;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/segment_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : segment_sequencer
//  Description : Double-buffered parameter bank and segment timer for the
//                waveform engine. Host writes fill a shadow bank; a commit
//                queues it with a duration. The sequencer copies shadow to
//                active (pulsing engine_reset), counts duration+1 cycles, then
//                swaps in a queued segment or stops and pulses finished.
//  Ports       : clk, reset (sync, active high)
//                wr_en/wr_field/wr_data, ptr_clear  - shadow load interface
//                duration, commit, abort             - segment control
//                active_amps/offsets/phasewords      - active bank (flat)
//                engine_reset, engine_active, finished, pending,
//                time_left, load_ptr, load_overflow  - status
//  Options     : `define SEGMENT_SEQUENCER_AUTO_REPEAT_EN adds input
//                repeat_en: an expiring segment with nothing queued is
//                replayed with its last loaded duration instead of finishing.
//  Revision    : 1.0 - initial release
// ============================================================================
module segment_sequencer
    import seg_seq_pkg::*;
#(
    parameter int NUM_CH = 64,
    parameter int DATA_W = c_DEFAULT_DATA_W,
    parameter int TIME_W = c_DEFAULT_TIME_W,
    parameter int PTR_W  = $clog2(NUM_CH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [1:0]               wr_field,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     ptr_clear,
    input  logic [TIME_W-1:0]        duration,
    input  logic                     commit,
    input  logic                     abort,
`ifdef SEGMENT_SEQUENCER_AUTO_REPEAT_EN
    input  logic                     repeat_en,
`endif
    output logic [NUM_CH*DATA_W-1:0] active_amps,
    output logic [NUM_CH*DATA_W-1:0] active_offsets,
    output logic [NUM_CH*DATA_W-1:0] active_phasewords,
    output logic                     engine_reset,
    output logic                     engine_active,
    output logic                     finished,
    output logic                     pending,
    output logic [TIME_W-1:0]        time_left,
    output logic [PTR_W-1:0]         load_ptr,
    output logic                     load_overflow
);

    localparam logic [PTR_W-1:0] c_PTR_FULL = PTR_W'(NUM_CH);

    seg_state_t          r_state, w_state_nxt;
    logic                r_commit_q;
    logic [TIME_W-1:0]   r_dur_q;
    logic                r_pending;
    logic [TIME_W-1:0]   r_pend_dur;
    logic [TIME_W-1:0]   r_time_left;
    logic                r_engine_reset;
    logic                r_finished;
    logic [PTR_W-1:0]    r_load_ptr;
    logic                r_load_overflow;

    logic                w_wr_valid, w_wr_accept, w_tl_zero, w_repeat;
    logic                w_load, w_decr, w_finish, w_reload;
    logic [NUM_CH*DATA_W-1:0] w_sh_amps, w_sh_offsets, w_sh_phasewords;

    // ---------------- shadow write path ----------------
    // ptr_clear takes precedence: a coincident write is dropped entirely
    assign w_wr_valid  = wr_en && !ptr_clear && (wr_field != 2'd3);
    assign w_wr_accept = w_wr_valid && (r_load_ptr != c_PTR_FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_ptr      <= '0;
            r_load_overflow <= 1'b0;
        end else if (ptr_clear) begin
            r_load_ptr      <= '0;
            r_load_overflow <= 1'b0;
        end else begin
            // Phaseword is the last field per channel, so it advances the pointer
            if (w_wr_accept && (wr_field == FIELD_PHASEWORD))
                r_load_ptr <= r_load_ptr + PTR_W'(1);
            if (w_wr_valid && (r_load_ptr == c_PTR_FULL))
                r_load_overflow <= 1'b1;
        end
    end

    seg_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .PTR_W(PTR_W)) u_shadow (
        .clk              (clk),
        .rst              (reset),
        .i_wr_en          (w_wr_accept),
        .i_wr_field       (wr_field),
        .i_wr_idx         (r_load_ptr),
        .i_wr_data        (wr_data),
        .i_load           (1'b0),
        .i_load_amps      ('0),
        .i_load_offsets   ('0),
        .i_load_phasewords('0),
        .o_amps           (w_sh_amps),
        .o_offsets        (w_sh_offsets),
        .o_phasewords     (w_sh_phasewords)
    );

    // Active bank copies the shadow's registered contents, so a write landing
    // on the same edge as a load is not part of the loaded segment.
    seg_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .PTR_W(PTR_W)) u_active (
        .clk              (clk),
        .rst              (reset),
        .i_wr_en          (1'b0),
        .i_wr_field       (2'd0),
        .i_wr_idx         ('0),
        .i_wr_data        ('0),
        .i_load           (w_load),
        .i_load_amps      (w_sh_amps),
        .i_load_offsets   (w_sh_offsets),
        .i_load_phasewords(w_sh_phasewords),
        .o_amps           (active_amps),
        .o_offsets        (active_offsets),
        .o_phasewords     (active_phasewords)
    );

    // ---------------- sequencer FSM ----------------
`ifdef SEGMENT_SEQUENCER_AUTO_REPEAT_EN
    logic [TIME_W-1:0] r_last_dur;
    assign w_repeat = repeat_en;
`else
    assign w_repeat = 1'b0;
`endif

    assign w_tl_zero = (r_time_left == '0);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort)
            w_state_nxt = IDLE;
        else if (r_state == IDLE && r_pending)
            w_state_nxt = RUN;
        else if (r_state == RUN && w_tl_zero && !r_pending && !w_repeat)
            w_state_nxt = IDLE;
    end

    always_comb begin
        w_load   = 1'b0;
        w_decr   = 1'b0;
        w_finish = 1'b0;
        w_reload = 1'b0;
        if (!abort) begin
            case (r_state)
                IDLE: w_load = r_pending;
                RUN: begin
                    if (!w_tl_zero)
                        w_decr = 1'b1;
                    else if (r_pending)
                        w_load = 1'b1;
                    else if (w_repeat)
                        w_reload = 1'b1;
                    else
                        w_finish = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_commit_q     <= 1'b0;
            r_dur_q        <= '0;
            r_pending      <= 1'b0;
            r_pend_dur     <= '0;
            r_time_left    <= '0;
            r_engine_reset <= 1'b0;
            r_finished     <= 1'b0;
        end else begin
            r_commit_q     <= commit;
            if (commit)
                r_dur_q    <= duration;
            r_engine_reset <= w_load || w_reload;
            r_finished     <= w_finish;

            if (r_commit_q)
                r_pend_dur <= r_dur_q;

            // A commit arriving with a load re-arms pending for the next segment
            if (abort)
                r_pending <= 1'b0;
            else if (r_commit_q)
                r_pending <= 1'b1;
            else if (w_load)
                r_pending <= 1'b0;

            if (abort)
                r_time_left <= '0;
            else if (w_load)
                r_time_left <= r_pend_dur;
`ifdef SEGMENT_SEQUENCER_AUTO_REPEAT_EN
            else if (w_reload)
                r_time_left <= r_last_dur;
`endif
            else if (w_decr)
                r_time_left <= r_time_left - TIME_W'(1);
        end
    end

`ifdef SEGMENT_SEQUENCER_AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (reset)
            r_last_dur <= '0;
        else if (w_load)
            r_last_dur <= r_pend_dur;
    end
`endif

    assign engine_reset  = r_engine_reset;
    assign engine_active = (r_state == RUN);
    assign finished      = r_finished;
    assign pending       = r_pending;
    assign time_left     = r_time_left;
    assign load_ptr      = r_load_ptr;
    assign load_overflow = r_load_overflow;

endmodule
`default_nettype wire

// File: tb/tb_segment_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_segment_sequencer
//  Description : Self-checking bench for segment_sequencer with NUM_CH=4.
//                Shadow-load vectors come from a table; segment timing,
//                back-to-back swap, abort, zero-length segments and the
//                optional auto-repeat are hand-written sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_segment_sequencer;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 16;
    localparam int TIME_W = 16;
    localparam int PTR_W  = 3;
    localparam int BUS_W  = NUM_CH * DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [1:0]        wr_field = 2'd0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              ptr_clear = 1'b0;
    logic [TIME_W-1:0] duration = '0;
    logic              commit = 1'b0;
    logic              abort = 1'b0;
    logic              repeat_en = 1'b0;
    logic [BUS_W-1:0]  active_amps, active_offsets, active_phasewords;
    logic              engine_reset, engine_active, finished, pending;
    logic [TIME_W-1:0] time_left;
    logic [PTR_W-1:0]  load_ptr;
    logic              load_overflow;

    segment_sequencer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIME_W(TIME_W), .PTR_W(PTR_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_en            (wr_en),
        .wr_field         (wr_field),
        .wr_data          (wr_data),
        .ptr_clear        (ptr_clear),
        .duration         (duration),
        .commit           (commit),
        .abort            (abort),
`ifdef SEGMENT_SEQUENCER_AUTO_REPEAT_EN
        .repeat_en        (repeat_en),
`endif
        .active_amps      (active_amps),
        .active_offsets   (active_offsets),
        .active_phasewords(active_phasewords),
        .engine_reset     (engine_reset),
        .engine_active    (engine_active),
        .finished         (finished),
        .pending          (pending),
        .time_left        (time_left),
        .load_ptr         (load_ptr),
        .load_overflow    (load_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              wr_en;
        logic [1:0]        field;
        logic [DATA_W-1:0] data;
        logic              pclr;
        logic [PTR_W-1:0]  exp_ptr;
        logic              exp_ovf;
    } vec_t;

    vec_t vecs[15];

    int n_cmp = 0;
    int n_err = 0;
    int act_cnt, rst_cnt, fin_cnt, drop_cnt;
    logic prev_act;
    logic [BUS_W-1:0] exp_amps, exp_offsets, exp_pws;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        act_cnt  = 0;
        rst_cnt  = 0;
        fin_cnt  = 0;
        drop_cnt = 0;
        prev_act = engine_active;
    endtask

    // Advance one edge and sample outputs 1 ns later
    task automatic tick();
        @(posedge clk);
        #1;
        if (engine_active) act_cnt++;
        if (engine_reset)  rst_cnt++;
        if (finished)      fin_cnt++;
        if (prev_act && !engine_active) drop_cnt++;
        prev_act = engine_active;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // ---------------- vector table ----------------
        for (int k = 0; k < NUM_CH; k++) begin
            vecs[3*k]   = '{1'b1, 2'd0, 16'h0010 + 16'(k), 1'b0, 3'(k),     1'b0};
            vecs[3*k+1] = '{1'b1, 2'd1, 16'h0020 + 16'(k), 1'b0, 3'(k),     1'b0};
            vecs[3*k+2] = '{1'b1, 2'd2, 16'h0030 + 16'(k), 1'b0, 3'(k + 1), 1'b0};
        end
        vecs[12] = '{1'b1, 2'd3, 16'hDEAD, 1'b0, 3'd4, 1'b0};  // field 3 ignored
        vecs[13] = '{1'b1, 2'd2, 16'hBEEF, 1'b0, 3'd4, 1'b1};  // overflow
        vecs[14] = '{1'b1, 2'd0, 16'h7777, 1'b1, 3'd0, 1'b0};  // clear wins

        for (int k = 0; k < NUM_CH; k++) begin
            exp_amps[k*DATA_W +: DATA_W]    = 16'h0010 + 16'(k);
            exp_offsets[k*DATA_W +: DATA_W] = 16'h0020 + 16'(k);
            exp_pws[k*DATA_W +: DATA_W]     = 16'h0030 + 16'(k);
        end

        // ---------------- reset ----------------
        ticks(3);
        chk("rst_engine_reset", 64'(engine_reset), 64'd0);
        chk("rst_engine_active", 64'(engine_active), 64'd0);
        chk("rst_finished", 64'(finished), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_time_left", 64'(time_left), 64'd0);
        chk("rst_load_ptr", 64'(load_ptr), 64'd0);
        chk("rst_active_amps", active_amps, 64'd0);
        reset = 1'b0;
        tick();

        // ---------------- shadow load table ----------------
        for (int i = 0; i < 15; i++) begin
            wr_en     = vecs[i].wr_en;
            wr_field  = vecs[i].field;
            wr_data   = vecs[i].data;
            ptr_clear = vecs[i].pclr;
            tick();
            wr_en     = 1'b0;
            ptr_clear = 1'b0;
            chk($sformatf("vec%0d_load_ptr", i), 64'(load_ptr), 64'(vecs[i].exp_ptr));
            chk($sformatf("vec%0d_overflow", i), 64'(load_overflow), 64'(vecs[i].exp_ovf));
        end

        // ---------------- single segment, duration 5 ----------------
        clear_counts();
        commit = 1'b1; duration = 16'd5;
        tick();                              // E0: commit registered
        commit = 1'b0;
        chk("t1_no_early_reset", 64'(engine_reset), 64'd0);
        tick();                              // E1: pending set
        chk("t1_pending", 64'(pending), 64'd1);
        tick();                              // E2: load
        chk("t1_engine_reset", 64'(engine_reset), 64'd1);
        chk("t1_time_left", 64'(time_left), 64'd5);
        chk("t1_pending_clr", 64'(pending), 64'd0);
        chk("t1_amps", active_amps, exp_amps);
        chk("t1_offsets", active_offsets, exp_offsets);
        chk("t1_phasewords", active_phasewords, exp_pws);
        ticks(9);
        chk("t1_active_cycles", 64'(act_cnt), 64'd6);
        chk("t1_finished_cnt", 64'(fin_cnt), 64'd1);
        chk("t1_reset_cnt", 64'(rst_cnt), 64'd1);
        chk("t1_idle", 64'(engine_active), 64'd0);
        chk("t1_amps_held", active_amps, exp_amps);

        // ---------------- back-to-back swap ----------------
        clear_counts();
        commit = 1'b1; duration = 16'd3;
        tick();                              // E0
        commit = 1'b0;
        tick();                              // E1
        wr_en = 1'b1; wr_field = 2'd0; wr_data = 16'h0040;
        tick();                              // E2: A loads, write lands same edge
        chk("t2_reset_a", 64'(engine_reset), 64'd1);
        chk("t2_amp0_prewrite", 64'(active_amps[15:0]), 64'h10);
        wr_field = 2'd1; wr_data = 16'h0050;
        tick();                              // E3
        wr_field = 2'd2; wr_data = 16'h0060; commit = 1'b1; duration = 16'd2;
        tick();                              // E4
        wr_en = 1'b0; commit = 1'b0;
        chk("t2_load_ptr", 64'(load_ptr), 64'd1);
        tick();                              // E5: A at zero, B pending
        chk("t2_pending_b", 64'(pending), 64'd1);
        chk("t2_tl_zero", 64'(time_left), 64'd0);
        tick();                              // E6: B loads
        exp_amps[15:0] = 16'h0040; exp_offsets[15:0] = 16'h0050; exp_pws[15:0] = 16'h0060;
        chk("t2_reset_b", 64'(engine_reset), 64'd1);
        chk("t2_time_left_b", 64'(time_left), 64'd2);
        chk("t2_amps_b", active_amps, exp_amps);
        chk("t2_offsets_b", active_offsets, exp_offsets);
        chk("t2_phasewords_b", active_phasewords, exp_pws);
        ticks(6);
        chk("t2_active_cycles", 64'(act_cnt), 64'd7);
        chk("t2_reset_cnt", 64'(rst_cnt), 64'd2);
        chk("t2_finished_cnt", 64'(fin_cnt), 64'd1);
        chk("t2_drops", 64'(drop_cnt), 64'd1);

        // ---------------- abort mid-run ----------------
        clear_counts();
        commit = 1'b1; duration = 16'd10;
        tick();                              // E0
        commit = 1'b0;
        ticks(2);                            // E2: load, tl=10
        commit = 1'b1; duration = 16'd9;
        tick();                              // E3
        commit = 1'b0;
        ticks(2);                            // E5
        chk("t4_tl7", 64'(time_left), 64'd7);
        chk("t4_pending", 64'(pending), 64'd1);
        clear_counts();
        abort = 1'b1;
        tick();                              // E6
        abort = 1'b0;
        chk("t4_inactive", 64'(engine_active), 64'd0);
        chk("t4_pending_clr", 64'(pending), 64'd0);
        chk("t4_tl_clr", 64'(time_left), 64'd0);
        ticks(4);
        chk("t4_no_finished", 64'(fin_cnt), 64'd0);
        chk("t4_no_reset", 64'(rst_cnt), 64'd0);
        chk("t4_still_idle", 64'(engine_active), 64'd0);
        chk("t4_amps_kept", active_amps, exp_amps);

        // ---------------- zero-length segment ----------------
        commit = 1'b1; duration = 16'd0;
        tick();                              // E0
        commit = 1'b0;
        ticks(2);                            // E2: load
        chk("t5_active", 64'(engine_active), 64'd1);
        chk("t5_reset", 64'(engine_reset), 64'd1);
        tick();                              // E3: finished
        chk("t5_finished", 64'(finished), 64'd1);
        chk("t5_idle", 64'(engine_active), 64'd0);
        commit = 1'b1; duration = 16'd1;     // commit on the finished cycle
        tick();                              // E4
        commit = 1'b0;
        chk("t5_fin_pulse", 64'(finished), 64'd0);
        tick();                              // E5
        chk("t5_pending2", 64'(pending), 64'd1);
        chk("t5_no_reset_yet", 64'(engine_reset), 64'd0);
        tick();                              // E6: new segment
        chk("t5_reset2", 64'(engine_reset), 64'd1);
        chk("t5_tl2", 64'(time_left), 64'd1);
        ticks(2);                            // E8
        chk("t5_finished2", 64'(finished), 64'd1);

`ifdef SEGMENT_SEQUENCER_AUTO_REPEAT_EN
        // ---------------- auto repeat ----------------
        tick();
        repeat_en = 1'b1;
        commit = 1'b1; duration = 16'd2;
        tick();                              // E0
        commit = 1'b0;
        tick();                              // E1
        clear_counts();
        ticks(9);                            // E2..E10
        chk("t6_reset_cnt", 64'(rst_cnt), 64'd3);
        chk("t6_no_finished", 64'(fin_cnt), 64'd0);
        chk("t6_tl", 64'(time_left), 64'd0);
        repeat_en = 1'b0;
        clear_counts();
        ticks(3);
        chk("t6_finished", 64'(fin_cnt), 64'd1);
        chk("t6_idle", 64'(engine_active), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
